// File: rtl/snn_image_loader_if.sv
// Handshake/bus bundle between snn_image_loader, the UART rx/tx pair and snn_core.
// The loader takes the slave modport; the environment driving it takes master.
interface snn_image_loader_if #(
    parameter int ADDR_W = 10
);
    logic              rx_rdy;
    logic [7:0]        rx_data;
    logic              tx_rdy;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              start;
    logic              done;
    logic [3:0]        digit;
    logic [ADDR_W-1:0] addr_input_unit;
    logic              q_input;
    logic [3:0]        digit_out;
    logic              busy;
    logic              overrun;

    modport slave (
        input  rx_rdy, rx_data, tx_rdy, done, digit, addr_input_unit,
        output tx_start, tx_data, start, q_input, digit_out, busy, overrun
    );

    modport master (
        output rx_rdy, rx_data, tx_rdy, done, digit, addr_input_unit,
        input  tx_start, tx_data, start, q_input, digit_out, busy, overrun
    );
endinterface

// File: rtl/snn_image_loader.sv
// SNN front end: unpacks UART bytes into a 1-bit pixel memory, runs snn_core, sends the digit back.
// Define ASCII_DIGIT_EN to transmit the result as an ASCII character instead of a raw nibble.
module snn_image_loader #(
    parameter int NUM_PIXELS = 784,
    parameter int ADDR_W     = 10
) (
    input logic               clk,
    input logic               rst_n,
    snn_image_loader_if.slave bus
);

    typedef enum logic [2:0] {
        LOAD,
        UNPACK,
        START_CORE,
        WAIT_DONE,
        SEND,
        WAIT_TX
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    state_t            state;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [7:0]        pend_data;
    logic              pend_full;
    logic              tx_armed;
    logic              mem [NUM_PIXELS];

    function automatic logic [7:0] encode_digit(input logic [3:0] d);
`ifdef ASCII_DIGIT_EN
        return 8'h30 + {4'h0, d};
`else
        return {4'h0, d};
`endif
    endfunction

    // NOTE: the pixel memory is deliberately left out of reset; every frame
    // rewrites all of it before snn_core is started, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (rst_n && state == UNPACK) begin
            mem[wr_addr] <= shreg[bit_cnt];
        end
    end

    // NOTE: strobes get a default of 0 at the top of the clocked block and are
    // overridden below; with non-blocking assignment the last write wins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= LOAD;
            wr_addr       <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            pend_data     <= '0;
            pend_full     <= 1'b0;
            tx_armed      <= 1'b0;
            bus.start     <= 1'b0;
            bus.tx_start  <= 1'b0;
            bus.tx_data   <= '0;
            bus.q_input   <= 1'b0;
            bus.digit_out <= '0;
            bus.busy      <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            bus.start    <= 1'b0;
            bus.tx_start <= 1'b0;
            bus.q_input  <= mem[bus.addr_input_unit];

            case (state)
                LOAD: begin
                    if (pend_full) begin
                        // A byte caught at the end of the previous unpack goes first.
                        shreg     <= pend_data;
                        pend_full <= 1'b0;
                        bit_cnt   <= '0;
                        state     <= UNPACK;
                        bus.busy  <= 1'b1;
                        if (bus.rx_rdy) begin
                            bus.overrun <= 1'b1;
                        end
                    end else if (bus.rx_rdy) begin
                        shreg    <= bus.rx_data;
                        bit_cnt  <= '0;
                        state    <= UNPACK;
                        bus.busy <= 1'b1;
                    end
                end

                UNPACK: begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bus.rx_rdy) begin
                        if (pend_full) begin
                            bus.overrun <= 1'b1;
                        end else begin
                            pend_data <= bus.rx_data;
                            pend_full <= 1'b1;
                        end
                    end
                    if (bit_cnt == 3'd7) begin
                        if (wr_addr == LAST_ADDR) begin
                            wr_addr   <= '0;
                            state     <= START_CORE;
                            bus.start <= 1'b1;
                        end else if (pend_full) begin
                            shreg     <= pend_data;
                            pend_full <= 1'b0;
                        end else begin
                            state    <= LOAD;
                            bus.busy <= 1'b0;
                        end
                    end
                end

                START_CORE: begin
                    if (bus.rx_rdy) begin
                        bus.overrun <= 1'b1;
                    end
                    state <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    if (bus.rx_rdy) begin
                        bus.overrun <= 1'b1;
                    end
                    if (bus.done) begin
                        bus.digit_out <= bus.digit;
                        state         <= SEND;
                    end
                end

                SEND: begin
                    if (bus.rx_rdy) begin
                        bus.overrun <= 1'b1;
                    end
                    if (bus.tx_rdy) begin
                        bus.tx_start <= 1'b1;
                        bus.tx_data  <= encode_digit(bus.digit_out);
                        tx_armed     <= 1'b0;
                        state        <= WAIT_TX;
                    end
                end

                WAIT_TX: begin
                    if (bus.rx_rdy) begin
                        bus.overrun <= 1'b1;
                    end
                    // The first cycle is skipped so a transmitter that has not yet
                    // lowered tx_rdy is not mistaken for one that already finished.
                    tx_armed <= 1'b1;
                    if (tx_armed && bus.tx_rdy) begin
                        state    <= LOAD;
                        bus.busy <= 1'b0;
                    end
                end

                default: begin
                    state    <= LOAD;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_image_loader.sv
// Self-checking bench for snn_image_loader: directed scenarios with random pixel data,
// checked against a frame-level model (pixel i = bit i%8 of byte i/8).
module tb_snn_image_loader;

    localparam int NUM_PIXELS = 784;
    localparam int ADDR_W     = 10;
    localparam int NUM_BYTES  = NUM_PIXELS / 8;

    logic clk = 1'b0;
    logic rst_n;

    snn_image_loader_if #(.ADDR_W(ADDR_W)) bus ();

    snn_image_loader #(
        .NUM_PIXELS(NUM_PIXELS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int tx_cnt    = 0;

    logic [7:0] frame [NUM_BYTES];

    always @(posedge clk) begin
        if (bus.start === 1'b1) start_cnt++;
        if (bus.tx_start === 1'b1) tx_cnt++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_pixel(input int i);
        logic [7:0] b;
        b = frame[i / 8];
        return b[i % 8];
    endfunction

    function automatic logic [7:0] exp_tx(input logic [3:0] d);
`ifdef ASCII_DIGIT_EN
        return 8'h30 + {4'h0, d};
`else
        return {4'h0, d};
`endif
    endfunction

    task automatic fill_random();
        for (int i = 0; i < NUM_BYTES; i++) frame[i] = 8'($urandom);
    endtask

    // Sends frame[first..last]; idles long enough between bytes that none is buffered.
    // The last byte returns right after its strobe edge so callers can time start.
    task automatic send_bytes(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            bus.rx_data = frame[i];
            bus.rx_rdy  = 1'b1;
            tick();
            bus.rx_rdy  = 1'b0;
            bus.rx_data = 8'($urandom);
            if (i != last) begin
                repeat (8 + $urandom_range(0, 3)) tick();
            end
        end
    endtask

    task automatic wait_start(input string tag, input int prev);
        for (int i = 0; i < 40; i++) begin
            if (bus.start === 1'b1) break;
            tick();
        end
        check({tag, "_start"}, bus.start, 1'b1);
        tick();
        check({tag, "_start_once"}, start_cnt, prev + 1);
        check({tag, "_busy"}, bus.busy, 1'b1);
    endtask

    task automatic check_pixels(input string tag);
        for (int i = 0; i < NUM_PIXELS; i++) begin
            bus.addr_input_unit = ADDR_W'(i);
            tick();
            check($sformatf("%s_pix%0d", tag, i), bus.q_input, exp_pixel(i));
        end
    endtask

    // Drives the core completion and the transmitter handshake from WAIT_DONE back to LOAD.
    task automatic finish_frame(input string tag, input logic [3:0] d, input int hold);
        int tx_prev;
        tx_prev = tx_cnt;
        bus.tx_rdy = (hold == 0);
        bus.done   = 1'b1;
        bus.digit  = d;
        tick();
        bus.done   = 1'b0;
        bus.digit  = 4'($urandom);
        check({tag, "_digit_out"}, bus.digit_out, d);
        repeat (hold) tick();
        check({tag, "_no_early_tx"}, tx_cnt, tx_prev);
        bus.tx_rdy = 1'b1;
        tick();
        check({tag, "_tx_start"}, bus.tx_start, 1'b1);
        check({tag, "_tx_data"}, bus.tx_data, exp_tx(d));
        bus.tx_rdy = 1'b0;
        tick();
        check({tag, "_tx_pulse"}, bus.tx_start, 1'b0);
        check({tag, "_tx_hold"}, bus.tx_data, exp_tx(d));
        repeat (3) tick();
        check({tag, "_busy_tx"}, bus.busy, 1'b1);
        bus.tx_rdy = 1'b1;
        tick();
        tick();
        check({tag, "_idle"}, bus.busy, 1'b0);
        check({tag, "_tx_once"}, tx_cnt, tx_prev + 1);
    endtask

    initial begin
        int sc;
        logic [3:0] d;
        logic [3:0] held;

        rst_n               = 1'b0;
        bus.rx_rdy          = 1'b0;
        bus.rx_data         = '0;
        bus.tx_rdy          = 1'b1;
        bus.done            = 1'b0;
        bus.digit           = '0;
        bus.addr_input_unit = '0;
        repeat (3) tick();

        check("rst_start", bus.start, 1'b0);
        check("rst_tx_start", bus.tx_start, 1'b0);
        check("rst_tx_data", bus.tx_data, 8'h00);
        check("rst_q_input", bus.q_input, 1'b0);
        check("rst_digit_out", bus.digit_out, 4'h0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        rst_n = 1'b1;
        tick();

        // All-A5 frame: start exactly 8 cycles after the final byte strobe.
        for (int i = 0; i < NUM_BYTES; i++) frame[i] = 8'hA5;
        sc = start_cnt;
        send_bytes(0, NUM_BYTES - 1);
        check("a5_busy", bus.busy, 1'b1);
        repeat (7) tick();
        check("a5_start_early", bus.start, 1'b0);
        tick();
        check("a5_start", bus.start, 1'b1);
        tick();
        check("a5_start_pulse", bus.start, 1'b0);
        check("a5_start_once", start_cnt, sc + 1);
        for (int i = 0; i < 8; i++) begin
            bus.addr_input_unit = ADDR_W'(i);
            tick();
            check($sformatf("a5_pix%0d", i), bus.q_input, exp_pixel(i));
        end
        finish_frame("a5", 4'd7, 4);

        // done in LOAD must be ignored.
        held = bus.digit_out;
        sc   = tx_cnt;
        bus.done  = 1'b1;
        bus.digit = 4'd3;
        repeat (3) tick();
        bus.done  = 1'b0;
        repeat (3) tick();
        check("ld_done_busy", bus.busy, 1'b0);
        check("ld_done_digit", bus.digit_out, held);
        check("ld_done_tx", tx_cnt, sc);

        // Random frames with random digits and transmitter latencies.
        for (int f = 0; f < 2; f++) begin
            fill_random();
            sc = start_cnt;
            send_bytes(0, NUM_BYTES - 1);
            wait_start($sformatf("rnd%0d", f), sc);
            check_pixels($sformatf("rnd%0d", f));
            d = 4'($urandom_range(0, 9));
            finish_frame($sformatf("rnd%0d", f), d, $urandom_range(0, 3));
        end
        check("rnd_overrun", bus.overrun, 1'b0);

        // Byte during WAIT_DONE is dropped: overrun set, memory untouched.
        fill_random();
        sc = start_cnt;
        send_bytes(0, NUM_BYTES - 1);
        wait_start("wd", sc);
        bus.rx_data = 8'hFF;
        bus.rx_rdy  = 1'b1;
        tick();
        bus.rx_rdy  = 1'b0;
        check("wd_overrun", bus.overrun, 1'b1);
        check("wd_busy", bus.busy, 1'b1);
        check_pixels("wd");
        finish_frame("wd", 4'd9, 0);

        // Reset mid-frame: partial image discarded, next frame starts at pixel 0.
        fill_random();
        sc = start_cnt;
        send_bytes(0, 49);
        repeat (3) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        check("mr_busy", bus.busy, 1'b0);
        check("mr_overrun", bus.overrun, 1'b0);
        rst_n = 1'b1;
        repeat (30) tick();
        check("mr_no_start", start_cnt, sc);
        fill_random();
        send_bytes(0, NUM_BYTES - 1);
        wait_start("mr", sc);
        check_pixels("mr");
        repeat (20) tick();
        check("mr_single_start", start_cnt, sc + 1);
        finish_frame("mr", 4'd0, 2);

        // Three bytes two cycles apart: second buffered, third dropped.
        fill_random();
        frame[0] = 8'hFF;
        frame[1] = 8'h00;
        frame[2] = 8'h0F;
        sc = start_cnt;
        check("pb_overrun_before", bus.overrun, 1'b0);
        bus.rx_data = 8'hFF; bus.rx_rdy = 1'b1; tick();
        bus.rx_rdy  = 1'b0;  tick();
        bus.rx_data = 8'h00; bus.rx_rdy = 1'b1; tick();
        bus.rx_rdy  = 1'b0;  tick();
        bus.rx_data = 8'h0F; bus.rx_rdy = 1'b1; tick();
        bus.rx_rdy  = 1'b0;
        check("pb_overrun", bus.overrun, 1'b1);
        repeat (16) tick();
        check("pb_idle", bus.busy, 1'b0);
        send_bytes(2, NUM_BYTES - 1);
        wait_start("pb", sc);
        check_pixels("pb");
        finish_frame("pb", 4'd5, 1);
        check("pb_overrun_sticky", bus.overrun, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
